if_stage: RTL

Instruction fetch stage: holds the program counter, fetches from instruction memory over a single-outstanding request/response handshake, and drives the IF/ID pipeline register consumed by `id_stage`. It honours the decode stage's hazard stall, absorbs one in-flight response in a holding buffer while stalled, and flushes and redirects on a resolved branch or jump from EX.

---
 rtl/if_stage_pkg.sv | 31 +++
 rtl/if_stage_if.sv | 22 ++
 rtl/if_hold_buf.sv | 46 ++++
 rtl/if_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the bubble instruction, the ebreak encoding and the hold-buffer entry.
package if_stage_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_e;

   // addi x0,x0,0 used for bubbles
   localparam logic [31:0] IF_NOP_INST    = 32'h0000_0013;
   // ebreak
   localparam logic [31:0] IF_EBREAK_INST = 32'h0010_0073;
   // Sequential fetch increment
   localparam logic [31:0] IF_PC_STEP     = 32'd4;

   // One {IR, PC} pair as carried by the hold buffer
   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
   } if_entry_t;

   // True when the instruction word is an ebreak
   function automatic logic is_ebreak(input logic [31:0] inst);
      return (inst == IF_EBREAK_INST);
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory request/response handshake.
// master: fetch stage (issues requests); slave: instruction memory.
interface if_stage_if;
   logic        req;     // level-held until the response arrives
   logic [31:0] addr;    // fetch address
   logic        rvalid;  // response valid for the current addr
   logic [31:0] rdata;   // instruction word

   modport master (
      output req,
      output addr,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output rvalid,
      output rdata
   );
endinterface

// File: rtl/if_hold_buf.sv
// One-entry {IR, PC} holding buffer. Captures a fetch response that lands
// while decode is stalled; clear has priority over load.
module if_hold_buf
   import if_stage_pkg::*;
(
   input  logic      clk,
   input  logic      rst,      // asynchronous, active-low
   input  logic      i_load,
   input  logic      i_clear,
   input  if_entry_t i_entry,
   output logic      o_full,
   output if_entry_t o_entry
);

   logic      r_full;
   if_entry_t r_entry;

   // Occupancy flag: clear wins, load fills, otherwise hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_full <= 1'b0;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_full <= 1'b1;
      end else begin
         r_full <= r_full;
      end
   end

   // Payload: captured on load, otherwise retained
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_entry.ir <= IF_NOP_INST;
         r_entry.pc <= 32'h0000_0000;
      end else if (i_load && !i_clear) begin
         r_entry <= i_entry;
      end else begin
         r_entry <= r_entry;
      end
   end

   assign o_full  = r_full;
   assign o_entry = r_entry;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage. Holds the PC, fetches over a single-outstanding
// request/response handshake and drives the IF/ID pipeline register.
// Optional feature macro: IF_EBREAK_HALT_EN -- when defined, an accepted
// ebreak stops fetching (HALT state, halted=1) until a redirect arrives.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
   input  logic              clk,
   input  logic              rst,             // asynchronous, active-low
   input  logic              stall,           // hazard stall from decode
   input  logic              redirect_valid,  // taken branch/jump from EX
   input  logic [31:0]       redirect_pc,
   if_stage_if.master        imem,
   output logic [31:0]       if_id_IR,
   output logic [31:0]       if_id_PC,
   output logic              if_id_valid_inst,
   output logic              halted
);

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_if_id_ir;
   logic [31:0]  r_if_id_pc;
   logic         r_if_id_valid;

   logic         w_req;
   logic         w_accept;
   logic         w_outstanding;
   logic         w_hold_full;
   logic         w_hold_load;
   logic         w_hold_clear;
   if_entry_t    w_hold_in;
   if_entry_t    w_hold_out;

   // Request qualification: requests only in REQ with room to absorb a response
   always_comb begin
      w_req         = 1'b0;
      w_outstanding = 1'b0;
      if (r_state == ST_REQ) begin
         w_req         = !w_hold_full;
         w_outstanding = !w_hold_full;
      end else if (r_state == ST_DROP) begin
         w_req         = 1'b0;
         w_outstanding = 1'b1;
      end else begin
         w_req         = 1'b0;
         w_outstanding = 1'b0;
      end
   end

   assign w_accept = w_req && imem.rvalid;

   // Hold-buffer control: flush on redirect, drain when stall drops,
   // capture a response accepted under stall
   always_comb begin
      w_hold_in.ir = imem.rdata;
      w_hold_in.pc = r_pc;
      w_hold_clear = 1'b0;
      w_hold_load  = 1'b0;
      if (redirect_valid) begin
         w_hold_clear = 1'b1;
         w_hold_load  = 1'b0;
      end else if (stall) begin
         w_hold_clear = 1'b0;
         w_hold_load  = w_accept;
      end else begin
         w_hold_clear = w_hold_full;
         w_hold_load  = 1'b0;
      end
   end

   if_hold_buf u_hold_buf (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_hold_load),
      .i_clear (w_hold_clear),
      .i_entry (w_hold_in),
      .o_full  (w_hold_full),
      .o_entry (w_hold_out)
   );

   // Fetch FSM and program counter; redirect overrides every state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
      end else if (redirect_valid) begin
         r_pc <= redirect_pc;
         // A request still in flight must have its stale response dropped
         if (w_outstanding && !imem.rvalid) begin
            r_state <= ST_DROP;
         end else begin
            r_state <= ST_REQ;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_REQ;
            end
            ST_REQ: begin
               if (w_accept) begin
                  r_pc <= r_pc + IF_PC_STEP;
`ifdef IF_EBREAK_HALT_EN
                  if (is_ebreak(imem.rdata)) begin
                     r_state <= ST_HALT;
                  end
`endif
               end
            end
            ST_DROP: begin
               if (imem.rvalid) begin
                  r_state <= ST_REQ;
               end
            end
`ifdef IF_EBREAK_HALT_EN
            ST_HALT: begin
               r_state <= ST_HALT;
            end
`endif
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // IF/ID register: flush > stall > drain hold buffer > new response > bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_if_id_ir    <= NOP_INST;
         r_if_id_pc    <= 32'h0000_0000;
         r_if_id_valid <= 1'b0;
      end else if (redirect_valid) begin
         r_if_id_ir    <= NOP_INST;
         r_if_id_valid <= 1'b0;
      end else if (stall) begin
         r_if_id_ir    <= r_if_id_ir;
         r_if_id_pc    <= r_if_id_pc;
         r_if_id_valid <= r_if_id_valid;
      end else if (w_hold_full) begin
         r_if_id_ir    <= w_hold_out.ir;
         r_if_id_pc    <= w_hold_out.pc;
         r_if_id_valid <= 1'b1;
      end else if (w_accept) begin
         r_if_id_ir    <= imem.rdata;
         r_if_id_pc    <= r_pc;
         r_if_id_valid <= 1'b1;
      end else begin
         r_if_id_ir    <= NOP_INST;
         r_if_id_valid <= 1'b0;
      end
   end

   assign imem.req         = w_req;
   assign imem.addr        = r_pc;
   assign if_id_IR         = r_if_id_ir;
   assign if_id_PC         = r_if_id_pc;
   assign if_id_valid_inst = r_if_id_valid;

`ifdef IF_EBREAK_HALT_EN
   assign halted = (r_state == ST_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule
